// File: rtl/inst_encoder.sv
// inst_encoder: packs structured instruction requests into RV32I words.
// Accepts one request per handshake and emits words through a registered
// valid/ready output stage. The LI pseudo-op becomes LUI (+ ADDI when the
// low 12 bits are non-zero) under a two-state FSM.
// Build option: define INST_ENC_RANGE_CHECK_EN to turn on immediate range
// checks. Out-of-range immediates then emit NOP_INST and pulse err_imm.
// Without it, immediates are truncated to field width and err_imm stays 0.
module inst_encoder #(
   parameter logic [31:0] NOP_INST = 32'h00000013,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [4:0]       req_rd,
   input  logic [4:0]       req_rs1,
   input  logic [4:0]       req_rs2,
   input  logic [2:0]       req_funct3,
   input  logic             req_funct7_b5,
   input  logic [31:0]      req_imm,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst_out,
   output logic             err_imm,
   output logic [CNT_W-1:0] inst_count
);

   // request operation codes
   localparam logic [3:0] OP_R      = 4'd0;
   localparam logic [3:0] OP_IARITH = 4'd1;
   localparam logic [3:0] OP_LOAD   = 4'd2;
   localparam logic [3:0] OP_STORE  = 4'd3;
   localparam logic [3:0] OP_BRANCH = 4'd4;
   localparam logic [3:0] OP_JALR   = 4'd5;
   localparam logic [3:0] OP_JAL    = 4'd6;
   localparam logic [3:0] OP_LUI    = 4'd7;
   localparam logic [3:0] OP_AUIPC  = 4'd8;
   localparam logic [3:0] OP_LI     = 4'd9;

   // RV32I major opcodes
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [0:0] {S_IDLE, S_LI2} state_t;

   // word: encoded instruction, err: un-encodable immediate,
   // li2: an LI whose low half still needs an ADDI
   typedef struct packed {
      logic [31:0] word;
      logic        err;
      logic        li2;
   } enc_t;

   function automatic logic in_range(input logic signed [31:0] v,
                                     input logic signed [31:0] lo,
                                     input logic signed [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   function automatic logic is_shift(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b101);
   endfunction

`ifdef INST_ENC_RANGE_CHECK_EN
   // true when the immediate does not fit the field of the requested format
   function automatic logic range_bad(input logic [3:0]  op,
                                      input logic [2:0]  f3,
                                      input logic [31:0] imm);
      logic signed [31:0] simm;
      logic               bad;
      simm = imm;
      bad  = 1'b0;
      case (op)
         OP_IARITH: begin
            if (is_shift(f3)) bad = (imm[31:5] != 27'd0);
            else              bad = !in_range(simm, -32'sd2048, 32'sd2047);
         end
         OP_LOAD, OP_STORE, OP_JALR:
            bad = !in_range(simm, -32'sd2048, 32'sd2047);
         OP_BRANCH:
            bad = !in_range(simm, -32'sd4096, 32'sd4094) || imm[0];
         OP_JAL:
            bad = !in_range(simm, -32'sd1048576, 32'sd1048574) || imm[0];
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction
`endif

   // format packing for every supported request
   function automatic enc_t encode(input logic [3:0]  op,
                                   input logic [4:0]  rd,
                                   input logic [4:0]  rs1,
                                   input logic [4:0]  rs2,
                                   input logic [2:0]  f3,
                                   input logic        f7b5,
                                   input logic [31:0] imm);
      enc_t               e;
      logic signed [31:0] simm;
      logic [19:0]        hi;
      e.word = NOP_INST;
      e.err  = 1'b0;
      e.li2  = 1'b0;
      simm   = imm;
      hi     = '0;
      case (op)
         OP_R:
            e.word = {1'b0, f7b5, 5'd0, rs2, rs1, f3, rd, OPC_R};
         OP_IARITH: begin
            if (is_shift(f3))
               e.word = {1'b0, f7b5, 5'd0, imm[4:0], rs1, f3, rd, OPC_IMM};
            else
               e.word = {imm[11:0], rs1, f3, rd, OPC_IMM};
         end
         OP_LOAD:
            e.word = {imm[11:0], rs1, f3, rd, OPC_LOAD};
         OP_STORE:
            e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
         OP_BRANCH:
            e.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
         OP_JALR:
            e.word = {imm[11:0], rs1, f3, rd, OPC_JALR};
         OP_JAL:
            e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         OP_LUI:
            e.word = {imm[31:12], rd, OPC_LUI};
         OP_AUIPC:
            e.word = {imm[31:12], rd, OPC_AUIPC};
         OP_LI: begin
            if (in_range(simm, -32'sd2048, 32'sd2047)) begin
               e.word = {imm[11:0], 5'd0, 3'b000, rd, OPC_IMM};
            end else begin
               // (imm + 0x800) >> 12 mod 2^20: adding 0x800 carries into
               // bit 12 exactly when imm[11] is set
               hi     = imm[31:12] + {19'd0, imm[11]};
               e.word = {hi, rd, OPC_LUI};
               e.li2  = (imm[11:0] != 12'd0);
            end
         end
         default: e.word = NOP_INST;
      endcase
`ifdef INST_ENC_RANGE_CHECK_EN
      if (range_bad(op, f3, imm)) begin
         e.word = NOP_INST;
         e.err  = 1'b1;
      end
`endif
      return e;
   endfunction

   state_t            state_q, state_d;
   enc_t              enc_p0;
   logic              accept_p0;
   logic              slot_free_p0;
   logic              li_emit_p0;
   logic [4:0]        li_rd_q;
   logic [11:0]       li_lo_q;
   logic [31:0]       word_p1;
   logic              vld_p1;
   logic              err_p1;
   logic [CNT_W-1:0]  cnt_q;

   // stage p0: combinational encode and handshake decisions
   always_comb enc_p0 = encode(req_op, req_rd, req_rs1, req_rs2,
                               req_funct3, req_funct7_b5, req_imm);

   assign slot_free_p0 = !vld_p1 || inst_ready;
   assign req_ready    = (state_q == S_IDLE) && slot_free_p0;
   assign accept_p0    = req_valid && req_ready;
   assign li_emit_p0   = (state_q == S_LI2) && slot_free_p0;

   // LI FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept_p0 && enc_p0.li2) state_d = S_LI2;
         S_LI2:  if (slot_free_p0)            state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // LI FSM state register; reset discards any pending second half
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // latch destination and low 12 bits for the deferred ADDI
   always_ff @(posedge clk) begin
      if (accept_p0 && enc_p0.li2) begin
         li_rd_q <= req_rd;
         li_lo_q <= req_imm[11:0];
      end
   end

   // stage p1: output register, held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         word_p1 <= '0;
         err_p1  <= 1'b0;
      end else begin
         err_p1 <= accept_p0 && enc_p0.err;
         if (accept_p0) begin
            word_p1 <= enc_p0.word;
            vld_p1  <= 1'b1;
         end else if (li_emit_p0) begin
            word_p1 <= {li_lo_q, li_rd_q, 3'b000, li_rd_q, OPC_IMM};
            vld_p1  <= 1'b1;
         end else if (inst_ready) begin
            vld_p1  <= 1'b0;
         end
      end
   end

   // count consumed words, wrapping at 2^CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cnt_q <= '0;
      else if (vld_p1 && inst_ready)    cnt_q <= cnt_q + CNT_W'(1);
   end

   assign inst_valid = vld_p1;
   assign inst_out   = word_p1;
   assign err_imm    = err_p1;
   assign inst_count = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with hand-computed RV32I words.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [4:0]  req_rd = '0;
   logic [4:0]  req_rs1 = '0;
   logic [4:0]  req_rs2 = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_funct7_b5 = 1'b0;
   logic [31:0] req_imm = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b1;
   logic [31:0] inst_out;
   logic        err_imm;
   logic [15:0] inst_count;

   int n_checks = 0;
   int n_err    = 0;

`ifdef INST_ENC_RANGE_CHECK_EN
   localparam logic [31:0] EXP_BIG_WORD = 32'h00000013;
   localparam logic        EXP_BIG_ERR  = 1'b1;
`else
   localparam logic [31:0] EXP_BIG_WORD = 32'h00008093;
   localparam logic        EXP_BIG_ERR  = 1'b0;
`endif

   inst_encoder dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_funct3(req_funct3), .req_funct7_b5(req_funct7_b5), .req_imm(req_imm),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
      .err_imm(err_imm), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // present a request and return 1 time unit after the accepting edge
   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                       input logic [31:0] imm);
      int waited;
      req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
      req_funct3 = f3; req_funct7_b5 = f7; req_imm = imm;
      req_valid = 1'b1;
      waited = 0;
      #1;
      while (!req_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_out", inst_out, 32'd0);
      check("rst_err", {31'd0, err_imm}, 32'd0);
      check("rst_count", {16'd0, inst_count}, 32'd0);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // add x3,x1,x2
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
      check("add_word", inst_out, 32'h002081B3);
      check("add_valid", {31'd0, inst_valid}, 32'd1);
      @(posedge clk); #1;
      check("add_count", {16'd0, inst_count}, 32'd1);

      // li x5,0x12345678 -> LUI then ADDI
      send(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678);
      check("li_lui", inst_out, 32'h123452B7);
      check("li2_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      check("li_addi", inst_out, 32'h67828293);
      check("li_addi_valid", {31'd0, inst_valid}, 32'd1);
      @(posedge clk); #1;
      check("li_count", {16'd0, inst_count}, 32'd3);

      // backpressure on sw x2,8(x1)
      inst_ready = 1'b0;
      send(4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8);
      for (int i = 0; i < 3; i++) begin
         check("bp_word", inst_out, 32'h0020A423);
         check("bp_valid", {31'd0, inst_valid}, 32'd1);
         check("bp_ready", {31'd0, req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      check("bp_count_held", {16'd0, inst_count}, 32'd3);
      inst_ready = 1'b1;
      #1;
      check("bp_ready_release", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      check("bp_count", {16'd0, inst_count}, 32'd4);
      check("bp_drained", {31'd0, inst_valid}, 32'd0);

      // beq x1,x2,-8
      send(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFF8);
      check("beq_word", inst_out, 32'hFE208CE3);
      check("beq_err", {31'd0, err_imm}, 32'd0);

      // addi x1,x1,4096: out of 12-bit range
      send(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd4096);
      check("big_word", inst_out, EXP_BIG_WORD);
      check("big_err", {31'd0, err_imm}, {31'd0, EXP_BIG_ERR});
      @(posedge clk); #1;
      check("big_err_pulse_end", {31'd0, err_imm}, 32'd0);

      // srai x1,x2,3
      send(4'd1, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3);
      check("srai_word", inst_out, 32'h40315093);

      // jal x1,+2048
      send(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
      check("jal_word", inst_out, 32'h001000EF);

      // unknown op -> NOP, no error
      send(4'd12, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd99999);
      check("unk_word", inst_out, 32'h00000013);
      check("unk_err", {31'd0, err_imm}, 32'd0);

      // li x7,-5 fits 12 bits -> single ADDI
      send(4'd9, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFB);
      check("li_small", inst_out, 32'hFFB00393);
      @(posedge clk); #1;
      check("li_small_single", {31'd0, inst_valid}, 32'd0);
      check("li_small_ready", {31'd0, req_ready}, 32'd1);

      // li x1,0x7FFFF800: hi wraps to 0x80000, lo = 0x800
      send(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h7FFFF800);
      check("li_wrap_lui", inst_out, 32'h800000B7);
      @(posedge clk); #1;
      check("li_wrap_addi", inst_out, 32'h80008093);

      // addi x0,x0,2047: upper boundary of I range
      send(4'd1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2047);
      check("imax_word", inst_out, 32'h7FF00013);
      check("imax_err", {31'd0, err_imm}, 32'd0);
      @(posedge clk); #1;
      check("total_count", {16'd0, inst_count}, 32'd13);

      // reset right after the LUI handshake of an LI
      send(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345678);
      check("rli_lui", inst_out, 32'h123452B7);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rli_valid", {31'd0, inst_valid}, 32'd0);
      check("rli_count", {16'd0, inst_count}, 32'd0);
      check("rli_out", inst_out, 32'd0);
      check("rli_idle", {31'd0, req_ready}, 32'd1);
      @(negedge clk) rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("rli_no_addi", {31'd0, inst_valid}, 32'd0);
      end
      check("rli_count_after", {16'd0, inst_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Encodes structured instruction requests into 32-bit RV32I instruction words. It performs the inverse of the opcode/control decode done in the decode stage.
- Used by the instruction-injection/boot path to feed the fetch buffer and by the self-test sequencer.
- Accepts one request per handshake and emits words through a registered valid/ready output stage.
- Expands the LI pseudo-op into a LUI+ADDI pair using a small FSM.

Parameters:
- NOP_INST, 32'h00000013, word emitted in place of an un-encodable request (ADDI x0,x0,0).
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_op  input  4  0=R, 1=I_ARITH, 2=LOAD, 3=STORE, 4=BRANCH, 5=JALR, 6=JAL, 7=LUI, 8=AUIPC, 9=LI, others=NOP.
- req_rd  input  5  destination register.
- req_rs1  input  5  source register 1.
- req_rs2  input  5  source register 2.
- req_funct3  input  3  funct3 field.
- req_funct7_b5  input  1  instruction bit 30, used by SUB/SRA/SRAI.
- req_imm  input  32  signed immediate, byte offset for BRANCH/JAL, full value for LUI/AUIPC/LI.
- inst_valid  output  1  inst_out holds a valid word.
- inst_ready  input  1  consumer accepts the word.
- inst_out  output  32  encoded instruction.
- err_imm  output  1  one-cycle pulse when a request is accepted but cannot be encoded.
- inst_count  output  CNT_W  number of words consumed (inst_valid && inst_ready).

Behaviour:
- Reset values: inst_valid=0, inst_out=0, err_imm=0, inst_count=0, FSM=S_IDLE. Reset is asynchronous and may occur at any time; any pending LI second half is discarded.
- Ready rule: req_ready = (state==S_IDLE) && (!inst_valid || inst_ready). It is combinational, so a word can be accepted on the same edge that drains the previous one.
- Latency: a word is registered on the accept edge and inst_valid rises one cycle later.
- Output register: while inst_valid && !inst_ready, inst_out is held stable.
- Opcodes: R 0110011, I_ARITH 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111.
- Field packing by format:
  - R: bit30 = funct7_b5, rest standard.
  - I: imm[11:0] -> bits 31:20.
  - S: imm[11:5] -> bits 31:25, imm[4:0] -> bits 11:7.
  - B: imm[12|10:5] -> bits 31:25, imm[4:1|11] -> bits 11:7.
  - J: imm[20|10:1|11|19:12] -> bits 31:12.
  - U: imm[31:12] -> bits 31:12; imm[11:0] ignored.
- I_ARITH shifts (funct3 001/101): bits 31:25 = {0, funct7_b5, 00000}, bits 24:20 = imm[4:0].
- Range checks:
  - I/S/JALR: -2048..2047.
  - BRANCH: -4096..4094, even.
  - JAL: -2^20..2^20-2, even.
  - Shifts: 0..31.
  - On violation: emit NOP_INST and pulse err_imm on the cycle after accept.
- Unknown req_op: emit NOP_INST without raising err_imm.
- LI handling:
  - If req_imm fits in 12 bits signed: emit a single ADDI rd,x0,imm.
  - Otherwise: hi = (req_imm + 32'h800) >> 12. Emit LUI rd,hi. If req_imm[11:0] != 0, latch rd and lo12, move to S_LI2, and emit ADDI rd,rd,lo12 when the output slot frees. Return to S_IDLE once that ADDI is registered.
  - req_ready stays low throughout S_LI2.
  - hi wraps mod 2^20; 32'h7FFFF800 and above are encoded correctly by wrap.
- inst_count increments on each output handshake and wraps at 2^CNT_W.

Optional Feature:
- Macro: INST_ENC_RANGE_CHECK_EN.
- Defined: range checks active as described under Behaviour.
- Undefined: no range checks; immediates are truncated to field width (odd branch/jump offsets drop bit 0); err_imm is tied to 0.
- LI expansion is unaffected in either case.

Test Plan:
- R add x3,x1,x2 (op=0, f3=0, f7b5=0), inst_ready=1 -> inst_out=0x002081B3 one cycle after accept; inst_count=1.
- LI x5,0x12345678 -> 0x123452B7, then 0x67828293 on consecutive output beats; req_ready=0 during S_LI2.
- Backpressure: hold inst_ready=0 for 3 cycles with a word pending -> inst_out stable, req_ready=0; release -> handshake, inst_count+1.
- BRANCH beq x1,x2,imm=-8 -> 0xFE208CE3. I_ARITH imm=4096 (range check on) -> 0x00000013 plus one err_imm pulse.
- Reset mid-LI: assert rst right after the LUI handshake -> inst_valid=0, FSM idle, ADDI never emitted, inst_count=0.
